// File: rtl/load_writeback_unit.sv
// rtl/load_writeback_unit.sv - single-outstanding load initiator writing extracted data to the register file
module load_writeback_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic [ADDR_WIDTH-1:0] req_rd,
    input  logic [2:0]            req_funct3,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [31:0]           mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rerr,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [31:0]             r_addr;
    logic [ADDR_WIDTH-1:0]   r_rd;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_value;

    logic                    w_accept;
    logic                    w_illegal;
    logic                    w_beat;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_extracted;

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_beat   = (r_state == S_DATA) && mem_rvalid;

    // Classify the incoming request: unknown opcodes and misaligned halves/words never reach memory
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            F3_LB, F3_LBU: w_illegal = 1'b0;
            F3_LH, F3_LHU: w_illegal = req_addr[0];
            F3_LW:         w_illegal = (req_addr[1:0] != 2'b00);
            default:       w_illegal = 1'b1;
        endcase
    end

    // Select the addressed byte and half-word lanes of the returned word
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        if (r_addr[1]) begin
            w_half = mem_rdata[31:16];
        end else begin
            w_half = mem_rdata[15:0];
        end
    end

    // Extend the selected lane according to the captured load type
    always_comb begin
        w_extracted = '0;
        case (r_funct3)
            F3_LB:   w_extracted = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU:  w_extracted = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:   w_extracted = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU:  w_extracted = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_extracted = mem_rdata;
        endcase
    end

    // State register; reset aborts any load in flight without a register write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the request at acceptance and the extracted value on a clean read beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_rd     <= '0;
            r_funct3 <= '0;
            r_value  <= '0;
        end else begin
            if (w_accept) begin
                r_addr   <= req_addr;
                r_rd     <= req_rd;
                r_funct3 <= req_funct3;
            end
            if (w_beat && !mem_rerr) begin
                r_value <= w_extracted;
            end
        end
    end

    // Next-state logic and Moore outputs; nothing below depends combinationally on the memory inputs
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        mem_arvalid  = 1'b0;
        mem_araddr   = 32'h0;
        mem_rready   = 1'b0;
        rf_wen       = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_illegal ? S_ERR : S_ADDR;
                end
            end
            S_ADDR: begin
                mem_arvalid = 1'b1;
                mem_araddr  = {r_addr[31:2], 2'b00};
                if (mem_arready) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    w_next_state = mem_rerr ? S_ERR : S_WB;
                end
            end
            S_WB: begin
                done = 1'b1;
                if (r_rd != '0) begin
                    rf_wen   = 1'b1;
                    rf_waddr = r_rd;
                    rf_wdata = r_value;
                end
                w_next_state = S_IDLE;
            end
            S_ERR: begin
                done         = 1'b1;
                err          = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_writeback_unit.sv
// tb/tb_load_writeback_unit.sv - directed self-checking bench for load_writeback_unit
`timescale 1ns/1ps
module tb_load_writeback_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic [2:0]  req_funct3;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        mem_rerr;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    load_writeback_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rd(req_rd), .req_funct3(req_funct3),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rerr(mem_rerr),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle req_ready"}, req_ready === 1'b1);
        check({tag, " idle arvalid"}, mem_arvalid === 1'b0);
        check({tag, " idle rready"}, mem_rready === 1'b0);
        check({tag, " idle rf_wen"}, rf_wen === 1'b0);
        check({tag, " idle done"}, done === 1'b0);
        check({tag, " idle err"}, err === 1'b0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [31:0] rdata,
                           input int ar_wait, input int r_wait, input logic rerr,
                           input logic exp_illegal, input logic exp_wen,
                           input logic [31:0] exp_wdata);
        check({tag, " req_ready"}, req_ready === 1'b1);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_rd     = rd;
        req_funct3 = f3;
        tick();
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        check({tag, " busy req_ready"}, req_ready === 1'b0);
        if (exp_illegal) begin
            check({tag, " illegal err"}, err === 1'b1);
            check({tag, " illegal done"}, done === 1'b1);
            check({tag, " illegal arvalid"}, mem_arvalid === 1'b0);
            check({tag, " illegal rf_wen"}, rf_wen === 1'b0);
        end else begin
            for (int i = 0; i < ar_wait; i++) begin
                mem_arready = 1'b0;
                check({tag, " stall arvalid"}, mem_arvalid === 1'b1);
                check({tag, " stall araddr"}, mem_araddr === {addr[31:2], 2'b00});
                tick();
            end
            mem_arready = 1'b1;
            check({tag, " arvalid"}, mem_arvalid === 1'b1);
            check({tag, " araddr"}, mem_araddr === {addr[31:2], 2'b00});
            tick();
            mem_arready = 1'b0;
            for (int i = 0; i < r_wait; i++) begin
                check({tag, " wait rready"}, mem_rready === 1'b1);
                tick();
            end
            check({tag, " rready"}, mem_rready === 1'b1);
            check({tag, " data arvalid"}, mem_arvalid === 1'b0);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            mem_rerr   = rerr;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            mem_rerr   = 1'b0;
            check({tag, " done"}, done === 1'b1);
            check({tag, " err"}, err === rerr);
            check({tag, " rf_wen"}, rf_wen === exp_wen);
            if (exp_wen) begin
                check({tag, " rf_waddr"}, rf_waddr === rd);
                check({tag, " rf_wdata"}, rf_wdata === exp_wdata);
            end
        end
        tick();
        check_idle(tag);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_rd      = 5'd0;
        req_funct3  = 3'd0;
        mem_arready = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;
        mem_rerr    = 1'b0;
        #1;
        check_idle("reset");
        check("reset araddr", mem_araddr === 32'h0);
        check("reset waddr", rf_waddr === 5'd0);
        check("reset wdata", rf_wdata === 32'h0);
        tick();
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        mem_rvalid = 1'b0;
        check_idle("stray");

        do_load("lw",     32'h80000004, 5'd5,  3'd2, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        do_load("lb3",    32'h80000003, 5'd6,  3'd0, 32'h80FF1234, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFFF80);
        do_load("lbu3",   32'h80000003, 5'd7,  3'd4, 32'h80FF1234, 0, 0, 1'b0, 1'b0, 1'b1, 32'h00000080);
        do_load("lb1",    32'h80000001, 5'd8,  3'd0, 32'h80FF1234, 0, 0, 1'b0, 1'b0, 1'b1, 32'h00000012);
        do_load("lbu2",   32'h80000002, 5'd9,  3'd4, 32'h80FF1234, 0, 0, 1'b0, 1'b0, 1'b1, 32'h000000FF);
        do_load("lh2",    32'h80000002, 5'd10, 3'd1, 32'h8001ABCD, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF8001);
        do_load("lh0",    32'h80000000, 5'd11, 3'd1, 32'h8001ABCD, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFFABCD);
        do_load("lhu2",   32'h80000002, 5'd31, 3'd5, 32'h8001ABCD, 0, 0, 1'b0, 1'b0, 1'b1, 32'h00008001);
        do_load("lhu_mis",32'h80000001, 5'd3,  3'd5, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        do_load("lw_mis", 32'h80000002, 5'd3,  3'd2, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        do_load("f3_3",   32'h80000000, 5'd3,  3'd3, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        do_load("f3_7",   32'h80000000, 5'd3,  3'd7, 32'h0,        0, 0, 1'b0, 1'b1, 1'b0, 32'h0);
        do_load("lw_rd0", 32'h80000010, 5'd0,  3'd2, 32'hCAFEF00D, 2, 3, 1'b0, 1'b0, 1'b0, 32'h0);
        do_load("rerr",   32'h80000008, 5'd4,  3'd2, 32'h11111111, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);

        mem_arready = 1'b1;
        req_valid   = 1'b1;
        req_addr    = 32'h80000020;
        req_rd      = 5'd12;
        req_funct3  = 3'd2;
        tick();
        req_valid   = 1'b0;
        tick();
        mem_arready = 1'b0;
        check("rst pre rready", mem_rready === 1'b1);
        rst = 1'b1;
        #1;
        check_idle("rst async");
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBADBAD00;
        #1;
        check("rst stale rready", mem_rready === 1'b0);
        tick();
        mem_rvalid = 1'b0;
        check_idle("rst after");
        check("rst after wdata", rf_wdata === 32'h0);

        mem_arready = 1'b1;
        do_load("post_rst", 32'h80000024, 5'd13, 3'd2, 32'h0BADF00D, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Initiator that turns one load request into a word read on the data-memory port, then writes the extracted, extended result into the register file write port (wen/waddr/wdata).
- Sits between the execute stage and the register file. It is the writing end of the register file: the register file only responds to writes, and this block issues them.
- Handles one request at a time.

Parameters:
ADDR_WIDTH, 5, register index width; matches the register file.
DATA_WIDTH, 32, register and memory data width; byte/half extraction is defined for 32 only.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  load request present
req_ready  output  1  block can accept a request
req_addr  input  32  byte address
req_rd  input  ADDR_WIDTH  destination register
req_funct3  input  3  0=LB 1=LH 2=LW 4=LBU 5=LHU; all other codes illegal
mem_arvalid  output  1  read address valid
mem_arready  input  1  memory accepts the address
mem_araddr  output  32  word-aligned address, {addr[31:2],2'b00}
mem_rvalid  input  1  read data valid
mem_rready  output  1  block accepts read data
mem_rdata  input  DATA_WIDTH  read word
mem_rerr  input  1  read error, qualified by mem_rvalid
rf_wen  output  1  register file write enable
rf_waddr  output  ADDR_WIDTH  register file write index
rf_wdata  output  DATA_WIDTH  register file write data
done  output  1  one-cycle pulse at completion (success or error)
err  output  1  one-cycle pulse together with done on an error completion

Behaviour:
- Reset: state=IDLE; all outputs 0 except req_ready=1; captured registers cleared.
- Reset asserted mid-operation: abort immediately to IDLE; no rf write.
- States:
  - IDLE: req_ready=1.
    - req_valid=1 captures addr, rd and funct3.
    - Illegal request → ERR. Illegal means an illegal funct3, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0.
    - Legal request → ADDR.
  - ADDR: mem_arvalid=1 with mem_araddr stable until mem_arready=1, then → DATA.
  - DATA: mem_rready=1.
    - mem_rvalid=1 and mem_rerr=1 → ERR.
    - mem_rvalid=1 and mem_rerr=0 → latch the extracted value, → WB.
  - WB: rf_wen=1 for exactly one cycle, except rf_wen=0 when rd==0. rf_waddr=rd, rf_wdata=value, done=1. → IDLE.
  - ERR: done=1, err=1, rf_wen=0, one cycle. → IDLE.
- req_ready=0 in every state except IDLE; a request is never accepted in WB or ERR.
- Extraction uses off=addr[1:0]:
  - LB/LBU: byte rdata[8*off+7:8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: half rdata[16*off[1]+15:16*off[1]], sign- or zero-extended.
  - LW: full word.
- Latency with a zero-wait memory: request accepted at cycle T; arvalid at T+1; rvalid at the earliest T+2; rf_wen at T+3. Minimum 3 cycles from acceptance to write; back-to-back throughput is 1 load per 4 cycles.
- mem_rvalid or mem_rdata toggling outside DATA is ignored (rready=0).
- mem_arready held high outside ADDR is ignored.
- rf_waddr and rf_wdata are don't-care when rf_wen=0; the implementation drives 0.

Test Plan:
- LW at addr 0x80000004, rd=5, memory returns 0xDEADBEEF with 0 wait → arvalid at T+1 with araddr 0x80000004; rf_wen=1 at T+3, waddr=5, wdata=0xDEADBEEF; done=1 for 1 cycle.
- LB and LBU at addr 0x80000003, rdata=0x80FF1234 → LB writes 0xFFFFFF80; LBU writes 0x00000080.
- LH at addr 0x80000002, rdata=0x8001ABCD → wdata=0xFFFF8001. LHU at addr 0x80000001 → err=1, done=1, no arvalid, rf_wen=0.
- LW with rd=0 and 2-cycle arready delay plus 3-cycle rvalid delay → araddr held stable through the stall; done=1 with rf_wen=0. Also funct3=3 → err=1 the cycle after acceptance.
- mem_rerr=1 with rvalid → err=1, done=1, rf_wen=0; req_ready=1 on the next cycle.
- rst asserted while in DATA, then rvalid=1 after release → all outputs at reset values, no rf_wen; the stale beat is not consumed (rready=0).
